// File: rtl/rram_seq_pkg.sv
// rtl/rram_seq_pkg.sv - shared types, register map and helpers for the RRAM pulse sequencer
package rram_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_FORM  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_SAMPLE,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Word offsets (wbs_adr_i[7:2])
  localparam logic [5:0] REG_CTRL   = 6'h00;
  localparam logic [5:0] REG_ADDR   = 6'h01;
  localparam logic [5:0] REG_PW     = 6'h02;
  localparam logic [5:0] REG_NPULSE = 6'h03;
  localparam logic [5:0] REG_GAP    = 6'h04;
  localparam logic [5:0] REG_STATUS = 6'h05;
  localparam logic [5:0] REG_RESULT = 6'h06;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_ABORT  = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  // Replace only the bytes whose enable is set
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rram_seq_wb_regs.sv
// rtl/rram_seq_wb_regs.sv - Wishbone slave, register file and sticky status bits
module rram_seq_wb_regs
  import rram_seq_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             busy_i,
  input  logic             done_set_i,
  input  logic             err_set_i,
  input  logic [CNT_W-1:0] result_i,
  output logic             start_o,
  output logic             abort_o,
  output op_e              op_o,
  output logic [3:0]       row_o,
  output logic [3:0]       col_o,
  output logic [CNT_W-1:0] pw_o,
  output logic [CNT_W-1:0] npulse_o,
  output logic [CNT_W-1:0] gap_o,
  output logic             irq_o
);

  logic             ack_q;
  logic [31:0]      dat_q;
  op_e              op_q;
  logic             irq_en_q;
  logic [3:0]       row_q;
  logic [3:0]       col_q;
  logic [CNT_W-1:0] pw_q;
  logic [CNT_W-1:0] np_q;
  logic [CNT_W-1:0] gap_q;
  logic             done_q;
  logic             err_q;
  logic             start_q;
  logic             abort_q;

  logic        req;
  logic        hit;
  logic        wr;
  logic        rd;
  logic [5:0]  idx;
  logic [31:0] rdata;
  logic [31:0] wmerge;
  logic [31:0] wbits;
  logic        st_w1c;
  logic        unused_bits;

  assign req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign idx    = wbs_adr_i[7:2];
  assign wr     = req & hit & wbs_we_i;
  assign rd     = req & hit & ~wbs_we_i;
  assign wmerge = be_merge(rdata, wbs_dat_i, wbs_sel_i);
  assign wbits  = be_merge(32'h0, wbs_dat_i, wbs_sel_i);
  assign st_w1c = wr && (idx == REG_STATUS);

  assign unused_bits = ^{wbs_adr_i[1:0], wmerge, wbits};

  // Readback mux; also the "old value" for byte-enable merging on writes
  always_comb begin
    rdata = '0;
    case (idx)
      REG_CTRL:   rdata = {28'h0, irq_en_q, op_q, 1'b0};
      REG_ADDR:   rdata = {20'h0, col_q, 4'h0, row_q};
      REG_PW:     rdata = 32'(pw_q);
      REG_NPULSE: rdata = 32'(np_q);
      REG_GAP:    rdata = 32'(gap_q);
      REG_STATUS: rdata = {29'h0, err_q, done_q, busy_i};
      REG_RESULT: rdata = 32'(result_i);
      default:    rdata = '0;
    endcase
  end

  // Bus handshake, register writes, command pulses and W1C status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      op_q     <= OP_READ;
      irq_en_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      pw_q     <= CNT_W'(1);
      np_q     <= CNT_W'(1);
      gap_q    <= CNT_W'(1);
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      ack_q   <= wbs_stb_i & wbs_cyc_i & ~ack_q;
      dat_q   <= rd ? rdata : '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      if (wr) begin
        case (idx)
          REG_CTRL: begin
            op_q     <= op_e'(wmerge[2:1]);
            irq_en_q <= wmerge[CTRL_IRQ_EN];
            start_q  <= wmerge[CTRL_START];
            abort_q  <= wmerge[CTRL_ABORT];
          end
          REG_ADDR: begin
            row_q <= wmerge[3:0];
            col_q <= wmerge[11:8];
          end
          REG_PW:     pw_q  <= wmerge[CNT_W-1:0];
          REG_NPULSE: np_q  <= wmerge[CNT_W-1:0];
          REG_GAP:    gap_q <= wmerge[CNT_W-1:0];
          default: ;
        endcase
      end
      done_q <= done_set_i | (done_q & ~(st_w1c & wbits[STAT_DONE]));
      err_q  <= err_set_i  | (err_q  & ~(st_w1c & wbits[STAT_ERR]));
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign start_o   = start_q;
  assign abort_o   = abort_q;
  assign op_o      = op_q;
  assign row_o     = row_q;
  assign col_o     = col_q;
  assign pw_o      = pw_q;
  assign npulse_o  = np_q;
  assign gap_o     = gap_q;
  assign irq_o     = done_q & irq_en_q;

endmodule

// File: rtl/rram_pulse_sequencer.sv
// rtl/rram_pulse_sequencer.sv - RRAM crossbar select/pulse/sense sequencer top
module rram_pulse_sequencer
  import rram_seq_pkg::*;
#(
  parameter int          N_ROWS     = 8,
  parameter int          N_COLS     = 8,
  parameter int          CNT_W      = 16,
  parameter int          SETTLE_CYC = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [N_ROWS-1:0] row_sel,
  output logic [N_COLS-1:0] col_sel,
  output logic [1:0]        op_mode,
  output logic              pulse_en,
  output logic              sense_en,
  input  logic              sense_in,
  output logic              busy,
  output logic              irq
);

  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_ROWS-1:0] ROW_ONE   = N_ROWS'(1);
  localparam logic [N_COLS-1:0] COL_ONE   = N_COLS'(1);

  logic             start;
  logic             abort;
  op_e              op_w;
  logic [3:0]       row_w;
  logic [3:0]       col_w;
  logic [CNT_W-1:0] pw_w;
  logic [CNT_W-1:0] np_w;
  logic [CNT_W-1:0] gap_w;
  logic             done_set;
  logic             err_set;
  logic             row_ok;
  logic             col_ok;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] left_q,   left_d;
  logic [CNT_W-1:0] result_q, result_d;
  op_e              op_sh_q,  op_sh_d;
  logic [3:0]       row_sh_q, row_sh_d;
  logic [3:0]       col_sh_q, col_sh_d;
  logic [CNT_W-1:0] pw_sh_q,  pw_sh_d;
  logic [CNT_W-1:0] gap_sh_q, gap_sh_d;
  logic             sense_s1_q;
  logic             sense_s2_q;

  rram_seq_wb_regs #(
    .CNT_W     (CNT_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .busy_i     (busy),
    .done_set_i (done_set),
    .err_set_i  (err_set),
    .result_i   (result_q),
    .start_o    (start),
    .abort_o    (abort),
    .op_o       (op_w),
    .row_o      (row_w),
    .col_o      (col_w),
    .pw_o       (pw_w),
    .npulse_o   (np_w),
    .gap_o      (gap_w),
    .irq_o      (irq)
  );

  assign row_ok = int'(row_w) < N_ROWS;
  assign col_ok = int'(col_w) < N_COLS;

  // Two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sense_s1_q <= 1'b0;
      sense_s2_q <= 1'b0;
    end else begin
      sense_s1_q <= sense_in;
      sense_s2_q <= sense_s1_q;
    end
  end

  // FSM state, phase counters, shadow copies and sense result
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      left_q   <= '0;
      result_q <= '0;
      op_sh_q  <= OP_READ;
      row_sh_q <= '0;
      col_sh_q <= '0;
      pw_sh_q  <= '0;
      gap_sh_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      op_sh_q  <= op_sh_d;
      row_sh_q <= row_sh_d;
      col_sh_q <= col_sh_d;
      pw_sh_q  <= pw_sh_d;
      gap_sh_q <= gap_sh_d;
    end
  end

  // Next-state: phase sequencing, start validation, abort override
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    op_sh_d  = op_sh_q;
    row_sh_d = row_sh_q;
    col_sh_d = col_sh_q;
    pw_sh_d  = pw_sh_q;
    gap_sh_d = gap_sh_q;
    done_set = 1'b0;
    err_set  = 1'b0;

    if (start && state_q != ST_IDLE) err_set = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (row_ok && col_ok) begin
            state_d  = ST_SETUP;
            cnt_d    = SETTLE_LD;
            op_sh_d  = op_w;
            row_sh_d = row_w;
            col_sh_d = col_w;
            pw_sh_d  = (pw_w  == '0) ? ONE : pw_w;
            gap_sh_d = (gap_w == '0) ? ONE : gap_w;
            left_d   = (op_w == OP_READ || np_w == '0) ? ONE : np_w;
          end else begin
            err_set  = 1'b1;
            done_set = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d = pw_sh_q - ONE;
          if (op_sh_q == OP_READ) begin
            state_d  = ST_SAMPLE;
            result_d = '0;
          end else begin
            state_d = ST_PULSE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          if (left_q == ONE) begin
            state_d = ST_HOLD;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = ST_GAP;
            cnt_d   = gap_sh_q - ONE;
            left_d  = left_q - ONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = pw_sh_q - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_SAMPLE: begin
        if (sense_s2_q && result_q != '1) result_d = result_q + ONE;
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - ONE;
      end
      ST_DONE: begin
        done_set = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      err_set = 1'b1;
      if (state_q != ST_DONE) state_d = ST_DONE;
    end
  end

  // Array drive: selects only while a run owns the array, gates by phase
  always_comb begin
    row_sel  = '0;
    col_sel  = '0;
    op_mode  = 2'b00;
    if (state_q inside {ST_SETUP, ST_PULSE, ST_GAP, ST_SAMPLE, ST_HOLD}) begin
      row_sel = ROW_ONE << row_sh_q;
      col_sel = COL_ONE << col_sh_q;
      op_mode = op_sh_q;
    end
    pulse_en = (state_q == ST_PULSE) || (state_q == ST_SAMPLE);
    sense_en = (state_q == ST_SAMPLE);
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rram_pulse_sequencer.sv
// tb/tb_rram_pulse_sequencer.sv - directed self-checking bench for rram_pulse_sequencer
module tb_rram_pulse_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [7:0] O_CTRL = 8'h00, O_ADDR = 8'h04, O_PW = 8'h08, O_NP = 8'h0C;
  localparam logic [7:0] O_GAP = 8'h10, O_STAT = 8'h14, O_RES = 8'h18;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic [7:0]  row_sel, col_sel;
  logic [1:0]  op_mode;
  logic        pulse_en, sense_en, sense_in, busy, irq;

  int checks   = 0;
  int failures = 0;

  int n_pulse, n_sense, n_rise, first_pulse, last_busy, first_irq, bad_inv, any_sel;
  int rise_c[4];
  logic [31:0] row_at, col_at, op_at, rd;

  always #5 clk = ~clk;

  rram_pulse_sequencer dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .row_sel   (row_sel),
    .col_sel   (col_sel),
    .op_mode   (op_mode),
    .pulse_en  (pulse_en),
    .sense_en  (sense_en),
    .sense_in  (sense_in),
    .busy      (busy),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns one ns after the ack edge
  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] be = 4'hF);
    logic got = 1'b0;
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = 1; adr = BASE | 32'(off); dat = d; sel = be;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    stb = 0; cyc = 0; we = 0; sel = 0;
    chk("wb_write_ack", 32'(got), 32'd1);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] d);
    logic got = 1'b0;
    d = '0;
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = 0; adr = BASE | 32'(off); sel = 4'hF;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; d = dat_o; end
    end
    stb = 0; cyc = 0; sel = 0;
    chk("wb_read_ack", 32'(got), 32'd1);
  endtask

  // Cycle 1 is the cycle right after the ack edge of the last write
  task automatic watch(input int ncyc, input int sense_cyc);
    logic prev_pe = 1'b0;
    n_pulse = 0; n_sense = 0; n_rise = 0; first_pulse = 0; last_busy = 0;
    first_irq = 0; bad_inv = 0; any_sel = 0; row_at = 0; col_at = 0; op_at = 0;
    for (int k = 0; k < 4; k++) rise_c[k] = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == sense_cyc) sense_in = 1'b1;
      if (pulse_en) begin
        n_pulse++;
        if (!prev_pe) begin
          if (n_rise < 4) rise_c[n_rise] = c;
          n_rise++;
          if (first_pulse == 0) begin
            first_pulse = c; row_at = 32'(row_sel); col_at = 32'(col_sel); op_at = 32'(op_mode);
          end
        end
        if ($countones(row_sel) != 1 || $countones(col_sel) != 1) bad_inv++;
      end
      prev_pe = pulse_en;
      if (sense_en) n_sense++;
      if (busy) last_busy = c;
      if (irq && first_irq == 0) first_irq = c;
      if (row_sel != 0 || col_sel != 0) any_sel = 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_pulse(input logic lvl, input string tag);
    int n = 0;
    while (pulse_en !== lvl && n < 100) begin @(posedge clk); #1; n++; end
    chk(tag, 32'(pulse_en), 32'(lvl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat = 0; sense_in = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_sel", 32'(row_sel), 0);
    chk("rst_col_sel", 32'(col_sel), 0);
    chk("rst_outs", {27'h0, op_mode, pulse_en, sense_en, busy}, 0);
    chk("rst_irq_ack", {30'h0, irq, ack}, 0);
    rst = 0;
    wb_read(O_PW, rd);   chk("rst_pw", rd, 1);
    wb_read(O_NP, rd);   chk("rst_npulse", rd, 1);
    wb_read(O_GAP, rd);  chk("rst_gap", rd, 1);
    wb_read(O_CTRL, rd); chk("rst_ctrl", rd, 0);
    wb_read(O_STAT, rd); chk("rst_status", rd, 0);
    wb_read(O_RES, rd);  chk("rst_result", rd, 0);
    wb_read(8'h1C, rd);  chk("unmapped_rd", rd, 0);

    // Byte enables and dropped unmapped writes
    wb_write(O_PW, 32'h1234_ABCD, 4'b0001);
    wb_read(O_PW, rd); chk("be_byte0", rd, 32'h00CD);
    wb_write(O_PW, 32'h0000_5600, 4'b0010);
    wb_read(O_PW, rd); chk("be_byte1", rd, 32'h56CD);
    wb_write(8'h20, 32'hFFFF_FFFF);
    wb_read(8'h20, rd); chk("unmapped_wr", rd, 0);

    // SET: row 2, col 5, PW 10, N 3, GAP 4 -> 1+4+30+8+4+1 = 48 cycles
    wb_write(O_ADDR, 32'h0502);
    wb_write(O_PW, 10);
    wb_write(O_NP, 3);
    wb_write(O_GAP, 4);
    wb_write(O_CTRL, 32'hB);
    watch(52, 0);
    chk("set_pulse_cycles", n_pulse, 30);
    chk("set_pulse_count", n_rise, 3);
    chk("set_first_pulse", first_pulse, 6);
    chk("set_spacing1", rise_c[1] - rise_c[0], 14);
    chk("set_spacing2", rise_c[2] - rise_c[1], 14);
    chk("set_row_sel", row_at, 32'h04);
    chk("set_col_sel", col_at, 32'h20);
    chk("set_op_mode", op_at, 1);
    chk("set_invariant", bad_inv, 0);
    chk("set_no_sense", n_sense, 0);
    chk("set_last_busy", last_busy, 48);
    chk("set_done_irq", first_irq, 49);
    wb_write(O_STAT, 32'h6);

    // READ: PW 20, NPULSE 7 ignored; synchronised sense high from sample cycle 5
    wb_write(O_PW, 20);
    wb_write(O_NP, 7);
    wb_write(O_CTRL, 32'h9);
    watch(40, 9);
    sense_in = 0;
    chk("rd_sense_cycles", n_sense, 20);
    chk("rd_pulse_cycles", n_pulse, 20);
    chk("rd_single_window", n_rise, 1);
    chk("rd_op_mode", op_at, 0);
    chk("rd_last_busy", last_busy, 30);
    chk("rd_done_irq", first_irq, 31);
    wb_read(O_RES, rd); chk("rd_result", rd, 15);
    wb_write(O_STAT, 32'h6);

    // Illegal row 9
    wb_write(O_ADDR, 32'h0509);
    wb_write(O_CTRL, 32'hB);
    watch(6, 0);
    chk("ill_no_select", any_sel, 0);
    chk("ill_busy", last_busy, 0);
    chk("ill_done_cycle", first_irq, 2);
    wb_read(O_STAT, rd); chk("ill_status", rd, 32'h6);
    wb_write(O_STAT, 32'h6);

    // Start while busy, then abort mid-pulse
    wb_write(O_ADDR, 32'h0502);
    wb_write(O_PW, 10);
    wb_write(O_NP, 3);
    wb_write(O_CTRL, 32'hB);
    wb_write(O_CTRL, 32'hB);
    wb_read(O_STAT, rd); chk("busy_start_err", rd, 32'h5);
    wait_pulse(1'b1, "abort_wait_pulse");
    wb_write(O_CTRL, 32'h18);
    chk("abort_pre_pulse", 32'(pulse_en), 1);
    @(posedge clk); #1;
    chk("abort_pulse_off", 32'(pulse_en), 0);
    chk("abort_sel_off", {16'h0, row_sel, col_sel}, 0);
    chk("abort_in_done", 32'(busy), 1);
    @(posedge clk); #1;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_irq", 32'(irq), 1);
    wb_read(O_STAT, rd); chk("abort_status", rd, 32'h6);
    wb_write(O_STAT, 32'h6);

    // FORM with irq: row 7 col 0, PW 2, N 2, GAP 0 -> 1
    wb_write(O_ADDR, 32'h0007);
    wb_write(O_PW, 2);
    wb_write(O_NP, 2);
    wb_write(O_GAP, 0);
    wb_write(O_CTRL, 32'hF);
    watch(20, 0);
    chk("form_pulse_cycles", n_pulse, 4);
    chk("form_spacing", rise_c[1] - rise_c[0], 3);
    chk("form_row_sel", row_at, 32'h80);
    chk("form_col_sel", col_at, 32'h01);
    chk("form_op_mode", op_at, 3);
    chk("form_last_busy", last_busy, 15);
    chk("form_irq", first_irq, 16);
    wb_write(O_STAT, 32'h2);
    chk("form_irq_clr", 32'(irq), 0);
    wb_read(O_STAT, rd); chk("form_status", rd, 0);

    // Reset during GAP
    wb_write(O_ADDR, 32'h0502);
    wb_write(O_PW, 3);
    wb_write(O_NP, 3);
    wb_write(O_GAP, 5);
    wb_write(O_CTRL, 32'h3);
    wait_pulse(1'b1, "gap_wait_pulse");
    wait_pulse(1'b0, "gap_wait_gap");
    chk("gap_busy", 32'(busy), 1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_sel", {16'h0, row_sel, col_sel}, 0);
    chk("mid_rst_outs", {27'h0, op_mode, pulse_en, sense_en, busy}, 0);
    rst = 0;
    wb_read(O_PW, rd);   chk("mid_rst_pw", rd, 1);
    wb_read(O_ADDR, rd); chk("mid_rst_addr", rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
